pmem_ctrl: RTL and testbench
============================

PMEM_CTRL -- requirements
Module: pmem_ctrl

Interface
REQ-001 SHALL have parameter DATA_W, default 8, meaning word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning request address width.
REQ-003 SHALL have parameter DEPTH, default 256, meaning implemented words; legal range 2..2**ADDR_W.
REQ-004 SHALL have port clk  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have ports req_valid  in  1, req_ready  out  1, req_we  in  1, req_addr  in  ADDR_W, req_wdata  in  DATA_W; request channel.
REQ-007 SHALL have ports rsp_valid  out  1, rsp_ready  in  1, rsp_rdata  out  DATA_W, rsp_err  out  1; read-response channel.
REQ-008 SHALL have port init_done  out  1, high once the clear sweep has finished.

Function
REQ-009 SHALL contain a state machine with states INIT and RUN; INIT SHALL be entered on reset.
REQ-010 In INIT SHALL write zero to one word per cycle, addresses 0 to DEPTH-1 ascending, then enter RUN; INIT SHALL last exactly DEPTH cycles.
REQ-011 SHALL hold req_ready low in INIT and set init_done high on the first RUN cycle.
REQ-012 A request SHALL transfer when req_valid and req_ready are both high on a rising edge.
REQ-013 In RUN, req_ready SHALL equal (!rsp_valid || rsp_ready), so a stalled response blocks new requests.
REQ-014 A write transfer SHALL update mem[req_addr] at that edge and SHALL NOT generate a response.
REQ-015 A read transfer SHALL assert rsp_valid on the next edge with rsp_rdata = mem[req_addr]; latency is 1 cycle.
REQ-016 rsp_valid, rsp_rdata and rsp_err SHALL hold stable while rsp_valid && !rsp_ready.
REQ-017 When a read transfers while the previous response is consumed on the same edge, the new response SHALL replace it without a bubble.
REQ-018 A request with req_addr >= DEPTH SHALL be accepted; a write SHALL be discarded; a read SHALL respond with rsp_rdata = 0 and rsp_err = 1.
REQ-019 Back-to-back write then read to the same address SHALL return the newly written data.
REQ-020 Any request to address DEPTH-1 SHALL behave normally; addresses SHALL NOT wrap.

Reset
REQ-021 On rst_n low, state SHALL become INIT, the sweep counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, init_done 0, and req_ready 0.
REQ-022 Reset asserted mid-INIT or mid-RUN SHALL abandon all activity and restart the sweep from address 0 after release; any pending response SHALL be lost.
REQ-023 Memory array contents SHALL NOT be reset directly; the INIT sweep SHALL clear them.

Configuration
REQ-024 Macro PMEM_PARITY_EN SHALL, when defined, store one even-parity bit per word, check it on every read, and set rsp_err = 1 on mismatch with rsp_rdata carrying the stored data.
REQ-025 With PMEM_PARITY_EN defined, an extra input inj_par_err (1 bit) SHALL invert the stored parity bit of the word written on that transfer.
REQ-026 Without PMEM_PARITY_EN, no parity storage and no inj_par_err port SHALL exist, and rsp_err SHALL signal only out-of-range reads.

Structure
REQ-027 The shared package SHALL hold the state enumeration (INIT, RUN) and the default width/depth constants.
REQ-028 The storage array SHALL be a sub-module pmem_array (single-port synchronous write, registered read); pmem_ctrl holds the FSM, handshake and error logic.

Verification
REQ-029 Reset release with DEPTH=256 -> req_ready low for 256 cycles, init_done rises on cycle 256, and a read of address 0x7F returns 0x00.
REQ-030 Write 0x5A to 0x10, then read 0x10 with rsp_ready high -> rsp_valid one cycle after the read transfer, rsp_rdata 0x5A, rsp_err 0.
REQ-031 Read 0x10 with rsp_ready held low for 3 cycles -> req_ready low and response held stable for those cycles, then one transfer when rsp_ready rises.
REQ-032 DEPTH=200, write 0xFF to 0xC8, then read 0xC8 -> rsp_err 1, rsp_rdata 0x00; mem[0xC7] unchanged.
REQ-033 Reset pulse at sweep address 100 -> sweep restarts at 0 and init_done is delayed a full DEPTH cycles.
REQ-034 PMEM_PARITY_EN: write 0x33 to 0x04 with inj_par_err=1, then read 0x04 -> rsp_rdata 0x33, rsp_err 1.

Source files
------------

// File: rtl/pmem_ctrl_pkg.sv
// Shared types and default geometry for the pmem_ctrl block.
// Optional build macro: PMEM_PARITY_EN (per-word even parity).
package pmem_ctrl_pkg;

   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DEPTH  = 256;

endpackage

// File: rtl/pmem_ctrl_array.sv
// Single-port word storage: synchronous write, registered read with read enable.
// Contents are never reset; the controller clears them with its sweep.
module pmem_array
   import pmem_ctrl_pkg::*;
#(
   parameter int WORD_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic              i_re,
   input  logic [IDX_W-1:0]  i_addr,
   input  logic [WORD_W-1:0] i_wdata,
   output logic [WORD_W-1:0] o_rdata
);

   logic [WORD_W-1:0] r_mem [DEPTH];
   logic [WORD_W-1:0] r_rdata;

   // The read register only moves on a read, so a stalled response stays put.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      if (i_re) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule

// File: rtl/pmem_ctrl.sv
// Memory controller: zero-fill sweep after reset, then valid/ready request and read-response channels.
// Optional build macro: PMEM_PARITY_EN adds a stored even-parity bit per word and the inj_par_err input.
module pmem_ctrl
   import pmem_ctrl_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
`ifdef PMEM_PARITY_EN
   input  logic              inj_par_err,
`endif
   output logic              init_done
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef PMEM_PARITY_EN
   localparam int WORD_W = DATA_W + 1;
`else
   localparam int WORD_W = DATA_W;
`endif
   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0] LAST_IX = IDX_W'(DEPTH - 1);

   state_t            r_state, w_state_next;
   logic [IDX_W-1:0]  r_sweep;
   logic              r_rsp_valid, r_rd_hit, r_oor_err;
   logic              w_in_range, w_ready, w_xfer, w_sweep_last;
   logic              w_arr_we, w_arr_re;
   logic [IDX_W-1:0]  w_arr_addr;
   logic [WORD_W-1:0] w_arr_wdata, w_arr_rdata, w_store_word;
   logic [DATA_W-1:0] w_rd_data;
   logic              w_par_bad;

   assign w_in_range   = ({1'b0, req_addr} < DEPTH_L);
   assign w_sweep_last = (r_sweep == LAST_IX);
   assign w_ready      = (r_state == RUN) && (!r_rsp_valid || rsp_ready);
   assign w_xfer       = req_valid && w_ready;

`ifdef PMEM_PARITY_EN
   assign w_store_word = {(^req_wdata) ^ inj_par_err, req_wdata};
`else
   assign w_store_word = req_wdata;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= INIT;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_arr_we     = 1'b0;
      w_arr_re     = 1'b0;
      w_arr_addr   = r_sweep;
      w_arr_wdata  = '0;
      case (r_state)
         INIT: begin
            w_arr_we = 1'b1;
            if (w_sweep_last) begin
               w_state_next = RUN;
            end
         end
         RUN: begin
            // Out-of-range requests are accepted but never touch the array.
            w_arr_addr  = req_addr[IDX_W-1:0];
            w_arr_wdata = w_store_word;
            w_arr_we    = w_xfer && req_we && w_in_range;
            w_arr_re    = w_xfer && !req_we && w_in_range;
         end
         default: w_state_next = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sweep <= '0;
      end else if (r_state == INIT && !w_sweep_last) begin
         r_sweep <= r_sweep + 1'b1;
      end
   end

   // A read that transfers while the old response is consumed simply overwrites it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rsp_valid <= 1'b0;
         r_rd_hit    <= 1'b0;
         r_oor_err   <= 1'b0;
      end else if (w_xfer && !req_we) begin
         r_rsp_valid <= 1'b1;
         r_rd_hit    <= w_in_range;
         r_oor_err   <= !w_in_range;
      end else if (rsp_ready) begin
         r_rsp_valid <= 1'b0;
      end
   end

   pmem_array #(
      .WORD_W (WORD_W),
      .DEPTH  (DEPTH),
      .IDX_W  (IDX_W)
   ) u_array (
      .clk     (clk),
      .i_we    (w_arr_we),
      .i_re    (w_arr_re),
      .i_addr  (w_arr_addr),
      .i_wdata (w_arr_wdata),
      .o_rdata (w_arr_rdata)
   );

   assign w_rd_data = w_arr_rdata[DATA_W-1:0];
`ifdef PMEM_PARITY_EN
   assign w_par_bad = r_rd_hit && (^w_arr_rdata);
`else
   assign w_par_bad = 1'b0;
`endif

   assign req_ready = w_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rd_hit ? w_rd_data : '0;
   assign rsp_err   = r_oor_err || w_par_bad;
   assign init_done = (r_state == RUN);

endmodule

// File: tb/tb_pmem_ctrl.sv
// Scoreboard bench for pmem_ctrl: two instances (DEPTH 256 and 200) share one stimulus stream.
// Builds with or without PMEM_PARITY_EN.
module tb_pmem_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       req_valid = 1'b0;
   logic       req_we = 1'b0;
   logic [7:0] req_addr = 8'h00;
   logic [7:0] req_wdata = 8'h00;
   logic       rsp_ready = 1'b1;
`ifdef PMEM_PARITY_EN
   logic       inj_par_err = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   task automatic check(input int d, input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL dut%0d %s got %0h want %0h at %0t", d, name, got, want, $time);
      end
   endtask

   genvar gi;
   for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int D = (gi == 0) ? 256 : 200;
      logic       req_ready, rsp_valid, rsp_err, init_done;
      logic [7:0] rsp_rdata;
      logic [7:0] m_mem [256];
      logic       m_bad [256];
      logic [8:0] exp_q [$];
      int         m_cyc = 0;

      pmem_ctrl #(.DATA_W(8), .ADDR_W(8), .DEPTH(D)) u_dut (
         .clk         (clk),
         .rst_n       (rst_n),
         .req_valid   (req_valid),
         .req_ready   (req_ready),
         .req_we      (req_we),
         .req_addr    (req_addr),
         .req_wdata   (req_wdata),
         .rsp_valid   (rsp_valid),
         .rsp_ready   (rsp_ready),
         .rsp_rdata   (rsp_rdata),
         .rsp_err     (rsp_err),
`ifdef PMEM_PARITY_EN
         .inj_par_err (inj_par_err),
`endif
         .init_done   (init_done)
      );

      // Reference model: clear sweep for the first D edges, then accept whenever no response is held.
      always @(posedge clk) begin
         int a;
         if (!rst_n) begin
            m_cyc = 0;
            exp_q.delete();
         end else begin
            if (m_cyc < D) begin
               m_mem[m_cyc] = 8'h00;
               m_bad[m_cyc] = 1'b0;
            end else if (req_valid && exp_q.size() == 0) begin
               a = int'(req_addr);
               if (req_we) begin
                  if (a < D) begin
                     m_mem[a] = req_wdata;
`ifdef PMEM_PARITY_EN
                     m_bad[a] = inj_par_err;
`else
                     m_bad[a] = 1'b0;
`endif
                  end
               end else begin
                  exp_q.push_back((a < D) ? {m_bad[a], m_mem[a]} : {1'b1, 8'h00});
               end
            end
            if (m_cyc < 100000) m_cyc++;
         end
      end

      // Monitor: compare what the DUT presents against the queue front, pop on handshake.
      always @(negedge clk) begin
         logic exp_done, exp_ready, exp_valid;
         if (!rst_n) begin
            check(gi, "reset_outputs", {20'h0, req_ready, rsp_valid, rsp_err, init_done, rsp_rdata}, 32'h0);
         end else begin
            exp_done  = (m_cyc >= D);
            exp_valid = (exp_q.size() != 0);
            exp_ready = exp_done && (!exp_valid || rsp_ready);
            check(gi, "init_done", {31'h0, init_done}, {31'h0, exp_done});
            check(gi, "req_ready", {31'h0, req_ready}, {31'h0, exp_ready});
            check(gi, "rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_valid});
            if (exp_valid) begin
               check(gi, "rsp_err_data", {23'h0, rsp_err, rsp_rdata}, {23'h0, exp_q[0]});
               if (rsp_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic idle(input int n);
      req_valid = 1'b0;
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic issue(input logic we, input logic [7:0] a, input logic [7:0] d, input logic inj);
      int n;
      req_valid = 1'b1;
      req_we    = we;
      req_addr  = a;
      req_wdata = d;
`ifdef PMEM_PARITY_EN
      inj_par_err = inj;
`else
      if (inj) $display("note: parity injection requested without parity build");
`endif
      n = 0;
      @(negedge clk);
      while (!g_dut[0].req_ready) begin
         n++;
         if (n > 50) begin
            n_checks++;
            n_errors++;
            $display("FAIL issue_timeout addr %0h got no req_ready want req_ready within 50 cycles", a);
            break;
         end
         @(negedge clk);
      end
      @(posedge clk);
      #1;
      req_valid = 1'b0;
`ifdef PMEM_PARITY_EN
      inj_par_err = 1'b0;
`endif
   endtask

   task automatic wait_init();
      int n;
      n = 0;
      while (!g_dut[0].init_done && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      n_checks++;
      if (!g_dut[0].init_done) begin
         n_errors++;
         $display("FAIL init_timeout got init_done 0 want 1 within 1000 cycles");
      end
   endtask

   initial begin
      #2 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;

      // Interrupt the sweep when it reaches address 100; it must start over.
      repeat (100) @(posedge clk);
      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_init();

      rsp_ready = 1'b1;
      issue(1'b0, 8'h7F, 8'h00, 1'b0);
      issue(1'b1, 8'h10, 8'h5A, 1'b0);
      issue(1'b0, 8'h10, 8'h00, 1'b0);
      idle(1);

      // Stalled response: hold rsp_ready low for 3 cycles with a read waiting behind it.
      rsp_ready = 1'b0;
      issue(1'b0, 8'h10, 8'h00, 1'b0);
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'h7F;
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      idle(2);

      issue(1'b1, 8'hC8, 8'hFF, 1'b0);
      issue(1'b0, 8'hC8, 8'h00, 1'b0);
      issue(1'b0, 8'hC7, 8'h00, 1'b0);
      issue(1'b1, 8'hC7, 8'hA5, 1'b0);
      issue(1'b0, 8'hC7, 8'h00, 1'b0);
      issue(1'b1, 8'hFF, 8'h3C, 1'b0);
      issue(1'b0, 8'hFF, 8'h00, 1'b0);
`ifdef PMEM_PARITY_EN
      issue(1'b1, 8'h04, 8'h33, 1'b1);
      issue(1'b0, 8'h04, 8'h00, 1'b0);
      issue(1'b1, 8'h04, 8'h33, 1'b0);
      issue(1'b0, 8'h04, 8'h00, 1'b0);
`endif
      idle(2);

      for (int i = 0; i < 800; i++) begin
         req_valid = ($urandom_range(0, 3) != 0);
         req_we    = $urandom_range(0, 1) == 1;
         if ($urandom_range(0, 4) == 0)
            req_addr = 8'($urandom_range(0, 255));
         else
            req_addr = ($urandom_range(0, 1) == 1 ? 8'hC0 : 8'h00) | 8'($urandom_range(0, 15));
         req_wdata = 8'($urandom_range(0, 255));
         rsp_ready = ($urandom_range(0, 3) != 0);
`ifdef PMEM_PARITY_EN
         inj_par_err = ($urandom_range(0, 7) == 0);
`endif
         @(posedge clk);
         #1;
      end
`ifdef PMEM_PARITY_EN
      inj_par_err = 1'b0;
`endif

      // Reset during RUN with a response held: it must vanish and memory must be cleared again.
      rsp_ready = 1'b0;
      req_valid = 1'b1;
      req_we    = 1'b0;
      req_addr  = 8'h05;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n     = 1'b1;
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      wait_init();
      issue(1'b0, 8'h05, 8'h00, 1'b0);
      issue(1'b0, 8'hC1, 8'h00, 1'b0);
      issue(1'b0, 8'h0F, 8'h00, 1'b0);
      idle(3);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
